keypad_conditioner: RTL

KEYPAD_CONDITIONER -- requirements
Module: keypad_conditioner

---
 rtl/door_pkg.sv | 30 +++
 rtl/debounce_cell.sv | 59 +++++
 rtl/keypad_conditioner.sv | 81 ++++++++
 3 files changed

// File: rtl/door_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : door_pkg
// Description : Shared button indices and default timing values for the
//               door controller front end.
// Revision    : 1.0
// ============================================================================
package door_pkg;

    localparam int BTN_1 = 1;
    localparam int BTN_2 = 2;
    localparam int BTN_3 = 3;
    localparam int BTN_4 = 4;

    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int c_TICK_DIV_DEFAULT        = 50_000_000;

    // Number of set bits in a 4-button vector; used for press arbitration.
    function automatic logic [2:0] count_ones(input logic [4:1] v);
        logic [2:0] n;
        n = '0;
        for (int i = BTN_1; i <= BTN_4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : debounce_cell
// Description : One button: 2-flop synchronizer, mismatch counter, debounced
//               level and a one-cycle flag when the level rises.
// Revision    : 1.0
// ============================================================================
module debounce_cell
    import door_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rise;
    logic               w_mismatch;

    assign w_mismatch = r_sync[1] ^ r_stable;

    // The level flips only after DEBOUNCE_CYCLES consecutive mismatching
    // cycles; any matching cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_rise <= 1'b0;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
                r_rise   <= ~r_stable;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/keypad_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : keypad_conditioner
// Description : Debounces four push-buttons, emits single press pulses with
//               multi-press rejection, and generates a periodic tick.
// Revision    : 1.0
// ============================================================================
module keypad_conditioner
    import door_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int TICK_DIV        = c_TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [4:1] btn_raw,
    input  logic       tick_clr,
    output logic [4:1] btn,
    output logic [4:1] btn_level,
    output logic       multi_press,
    output logic       tick_1s
);

    localparam int                  c_TICK_W    = $clog2(TICK_DIV) + 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

    logic [4:1]          w_level;
    logic [4:1]          w_rise;
    logic [2:0]          w_rise_cnt;
    logic [4:1]          r_btn;
    logic                r_multi;
    logic [c_TICK_W-1:0] r_tick_cnt;

    generate
        for (genvar gi = BTN_1; gi <= BTN_4; gi++) begin : g_cell
            debounce_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cell (
                .clk     (clk),
                .rst     (rs),
                .i_raw   (btn_raw[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_rise_cnt = count_ones(w_rise);

    // Simultaneous presses are ambiguous to the door FSM, so they are
    // reported only through multi_press.
    always_ff @(posedge clk) begin
        if (rs) begin
            r_btn   <= '0;
            r_multi <= 1'b0;
        end else begin
            r_btn   <= (w_rise_cnt == 3'd1) ? w_rise : 4'b0000;
            r_multi <= (w_rise_cnt >= 3'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            r_tick_cnt <= '0;
        end else if (tick_clr) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign btn         = r_btn;
    assign btn_level   = w_level;
    assign multi_press = r_multi;
    assign tick_1s     = (r_tick_cnt == c_TICK_LAST) & ~tick_clr;

endmodule
`default_nettype wire
